// File: rtl/riscv_core_icache_axi_rd_master.sv
// Purpose : icache line-refill engine; one AXI4 INCR read burst per request,
//           beats assembled into a single cache line.
// Latency : request -> ARVALID 1 cycle; last accepted beat -> o_mem_done 1 cycle.
// Backpressure: ARVALID held with stable address until ARREADY; RREADY high for
//           the whole R phase (no R backpressure); one transaction in flight.
//
// Ports:
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_mem_req, i_addr         line-fill request level and miss address
//   o_mem_done, o_block       one-cycle done pulse and assembled line
//   o_bus_err                 fault flag, only ever high together with o_mem_done
//   o_ar*, i_arready          AXI4 read-address channel
//   i_r*, o_rready            AXI4 read-data channel
module riscv_core_icache_axi_rd_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_WIDTH     = 256,
  parameter int AXI_DATA_WIDTH = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_mem_req,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  output logic                      o_mem_done,
  output logic [LINE_WIDTH-1:0]     o_block,
  output logic                      o_bus_err,
  output logic [ADDR_WIDTH-1:0]     o_araddr,
  output logic [7:0]                o_arlen,
  output logic [2:0]                o_arsize,
  output logic [1:0]                o_arburst,
  output logic                      o_arvalid,
  input  logic                      i_arready,
  input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]                i_rresp,
  input  logic                      i_rlast,
  input  logic                      i_rvalid,
  output logic                      o_rready
);

  localparam int BEATS      = LINE_WIDTH / AXI_DATA_WIDTH;
  localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LINE_BYTES = LINE_WIDTH / 8;

  // Clears the byte-in-line offset bits so the burst starts on a line boundary.
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~(ADDR_WIDTH'(LINE_BYTES - 1));
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic             line_full;   // last slot written; further beats are overflow
  logic             err_sticky;

  // Burst shape never changes: a full line of full-width beats.
  assign o_arlen   = 8'(BEATS - 1);
  assign o_arsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign o_arburst = 2'b01;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (i_mem_req)           state_nxt = S_AR;
      S_AR:   if (i_arready)           state_nxt = S_R;
      // Only RLAST ends the burst; a missing RLAST parks here by design.
      S_R:    if (i_rvalid && i_rlast) state_nxt = S_DONE;
      S_DONE:                          state_nxt = S_IDLE;
      default:                         state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state (plus the registered error sticky), so no
  // input reaches an output combinationally.
  always_comb begin
    o_arvalid  = 1'b0;
    o_rready   = 1'b0;
    o_mem_done = 1'b0;
    o_bus_err  = 1'b0;
    case (state)
      S_AR:   o_arvalid = 1'b1;
      S_R:    o_rready  = 1'b1;
      S_DONE: begin
        o_mem_done = 1'b1;
        o_bus_err  = err_sticky;
      end
      default: ;
    endcase
  end

  // Datapath: address latch, beat assembly, error tracking.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_araddr   <= '0;
      o_block    <= '0;
      beat_cnt   <= '0;
      line_full  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_mem_req) begin
            o_araddr   <= i_addr & LINE_MASK;
            beat_cnt   <= '0;
            line_full  <= 1'b0;
            err_sticky <= 1'b0;
          end
        end
        S_R: begin
          if (i_rvalid) begin
            if (line_full) begin
              // Beat beyond the line: drop the data, flag the burst.
              err_sticky <= 1'b1;
            end else begin
              o_block[beat_cnt*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= i_rdata;
              if (beat_cnt == LAST_BEAT) begin
                line_full <= 1'b1;
              end else begin
                beat_cnt <= beat_cnt + 1'b1;
              end
            end
            if (i_rresp != 2'b00) begin
              err_sticky <= 1'b1;
            end
            // RLAST before the final slot means a short line.
            if (i_rlast && (beat_cnt != LAST_BEAT)) begin
              err_sticky <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_core_icache_axi_rd_master.sv
module tb_riscv_core_icache_axi_rd_master;

  localparam int AW    = 32;
  localparam int LW    = 256;
  localparam int DW    = 64;
  localparam int BEATS = LW / DW;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_mem_req;
  logic [AW-1:0] i_addr;
  logic          o_mem_done;
  logic [LW-1:0] o_block;
  logic          o_bus_err;
  logic [AW-1:0] o_araddr;
  logic [7:0]    o_arlen;
  logic [2:0]    o_arsize;
  logic [1:0]    o_arburst;
  logic          o_arvalid;
  logic          i_arready;
  logic [DW-1:0] i_rdata;
  logic [1:0]    i_rresp;
  logic          i_rlast;
  logic          i_rvalid;
  logic          o_rready;

  riscv_core_icache_axi_rd_master #(
    .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .AXI_DATA_WIDTH(DW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_mem_req(i_mem_req), .i_addr(i_addr),
    .o_mem_done(o_mem_done), .o_block(o_block), .o_bus_err(o_bus_err),
    .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
    .o_arburst(o_arburst), .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast),
    .i_rvalid(i_rvalid), .o_rready(o_rready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [LW-1:0] blk;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            vectors     = 0;
  int            miscompares = 0;
  int            done_seen   = 0;
  logic [LW-1:0] model_blk;
  int            model_slot;
  logic          model_err;

  // Completion monitor: each done pulse is matched against the scoreboard.
  always @(negedge i_clk) begin
    if (o_mem_done === 1'b1) begin
      done_seen++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL done_unexpected: o_mem_done=1 required 0 (no fill pending)");
      end else begin
        mon_e = sb.pop_front();
        if (o_block !== mon_e.blk) begin
          miscompares++;
          $display("FAIL block: got %h required %h", o_block, mon_e.blk);
        end
        vectors++;
        if (o_bus_err !== mon_e.err) begin
          miscompares++;
          $display("FAIL bus_err: got %b required %b", o_bus_err, mon_e.err);
        end
      end
    end else if (!i_rst && o_bus_err !== 1'b0) begin
      vectors++;
      miscompares++;
      $display("FAIL bus_err_alone: got %b required 0", o_bus_err);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_fill(input logic [AW-1:0] addr, input bit hold_req);
    i_mem_req  = 1'b1;
    i_addr     = addr;
    tick();
    if (!hold_req) i_mem_req = 1'b0;
    model_slot = 0;
    model_err  = 1'b0;
  endtask

  task automatic ar_phase(input logic [AW-1:0] exp_addr, input int stall);
    vectors++;
    if (o_arvalid !== 1'b1 || o_araddr !== exp_addr || o_rready !== 1'b0) begin
      miscompares++;
      $display("FAIL ar_first: arvalid=%b araddr=%h rready=%b required 1 %h 0",
               o_arvalid, o_araddr, o_rready, exp_addr);
    end
    vectors++;
    if ({o_arlen, o_arsize, o_arburst} !== {8'd3, 3'd3, 2'b01}) begin
      miscompares++;
      $display("FAIL ar_ctrl: len=%0d size=%0d burst=%0d required 3 3 1",
               o_arlen, o_arsize, o_arburst);
    end
    i_arready = 1'b0;
    for (int k = 0; k < stall; k++) begin
      tick();
      vectors++;
      if (o_arvalid !== 1'b1 || o_araddr !== exp_addr || o_rready !== 1'b0) begin
        miscompares++;
        $display("FAIL ar_hold[%0d]: arvalid=%b araddr=%h rready=%b required 1 %h 0",
                 k, o_arvalid, o_araddr, o_rready, exp_addr);
      end
    end
    i_arready = 1'b1;
    tick();
    i_arready = 1'b0;
    vectors++;
    if (o_arvalid !== 1'b0 || o_rready !== 1'b1) begin
      miscompares++;
      $display("FAIL ar_handshake: arvalid=%b rready=%b required 0 1", o_arvalid, o_rready);
    end
  endtask

  // Drive one R beat (accepted on the next edge) and update the line model.
  task automatic send_beat(input logic [DW-1:0] d, input logic [1:0] resp, input bit last);
    exp_t e;
    i_rvalid = 1'b1;
    i_rdata  = d;
    i_rresp  = resp;
    i_rlast  = last;
    if (model_slot < BEATS) begin
      model_blk[model_slot*DW +: DW] = d;
      model_slot++;
    end else begin
      model_err = 1'b1;
    end
    if (resp != 2'b00) model_err = 1'b1;
    if (last) begin
      if (model_slot != BEATS) model_err = 1'b1;
      e.blk = model_blk;
      e.err = model_err;
      sb.push_back(e);
    end
    tick();
    i_rvalid = 1'b0;
    i_rlast  = 1'b0;
    i_rresp  = 2'b00;
  endtask

  task automatic gap();
    i_rvalid = 1'b0;
    tick();
  endtask

  task automatic check_done(input int done_before);
    vectors++;
    if (o_mem_done !== 1'b1 || o_rready !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse: done=%b rready=%b required 1 0", o_mem_done, o_rready);
    end
    tick();
    vectors++;
    if (o_mem_done !== 1'b0 || done_seen !== done_before + 1) begin
      miscompares++;
      $display("FAIL done_once: done=%b pulses=%0d required 0 %0d",
               o_mem_done, done_seen - done_before, 1);
    end
  endtask

  task automatic four_beats(input logic [DW-1:0] base);
    for (int b = 0; b < BEATS; b++) send_beat(base * DW'(b + 1), 2'b00, b == BEATS - 1);
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_mem_req = 1'b0; i_addr = '0; i_arready = 1'b0;
    i_rdata = '0; i_rresp = 2'b00; i_rlast = 1'b0; i_rvalid = 1'b0;
    model_blk = '0;
    #12;
    vectors++;
    if ({o_arvalid, o_rready, o_mem_done, o_bus_err} !== 4'b0 || o_araddr !== '0 || o_block !== '0) begin
      miscompares++;
      $display("FAIL reset: ctl=%b araddr=%h block=%h required 0", 
               {o_arvalid, o_rready, o_mem_done, o_bus_err}, o_araddr, o_block);
    end
    tick();
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_fill();
    int d0 = done_seen;
    start_fill(32'h0000_1234, 1'b0);
    ar_phase(32'h0000_1220, 0);
    send_beat(64'h1111_1111_1111_1111, 2'b00, 1'b0);
    send_beat(64'h2222_2222_2222_2222, 2'b00, 1'b0);
    send_beat(64'h3333_3333_3333_3333, 2'b00, 1'b0);
    send_beat(64'h4444_4444_4444_4444, 2'b00, 1'b1);
    check_done(d0);
  endtask

  task automatic test_ar_backpressure();
    int d0 = done_seen;
    start_fill(32'h8000_0047, 1'b0);
    ar_phase(32'h8000_0040, 5);
    four_beats(64'h0101_0000_0000_0001);
    check_done(d0);
  endtask

  task automatic test_r_gaps();
    int d0 = done_seen;
    start_fill(32'h0000_ABCD, 1'b0);
    ar_phase(32'h0000_ABC0, 0);
    send_beat(64'hA0A0_0000_0000_0001, 2'b00, 1'b0);
    gap();
    gap();
    send_beat(64'hA0A0_0000_0000_0002, 2'b00, 1'b0);
    send_beat(64'hA0A0_0000_0000_0003, 2'b00, 1'b0);
    gap();
    vectors++;
    if (done_seen !== d0 || o_rready !== 1'b1) begin
      miscompares++;
      $display("FAIL gaps_early_done: pulses=%0d rready=%b required 0 1", done_seen - d0, o_rready);
    end
    send_beat(64'hA0A0_0000_0000_0004, 2'b00, 1'b1);
    check_done(d0);
  endtask

  task automatic test_slverr();
    int d0 = done_seen;
    start_fill(32'h0000_2000, 1'b0);
    ar_phase(32'h0000_2000, 1);
    send_beat(64'h5555_0000_0000_0000, 2'b00, 1'b0);
    send_beat(64'h6666_0000_0000_0000, 2'b00, 1'b0);
    send_beat(64'h7777_0000_0000_0000, 2'b10, 1'b0);
    vectors++;
    if (o_rready !== 1'b1) begin
      miscompares++;
      $display("FAIL slverr_rready: got %b required 1", o_rready);
    end
    send_beat(64'h8888_0000_0000_0000, 2'b00, 1'b1);
    check_done(d0);
  endtask

  task automatic test_early_rlast();
    int d0 = done_seen;
    start_fill(32'h0000_3010, 1'b0);
    ar_phase(32'h0000_3000, 0);
    send_beat(64'h9999_0000_0000_0001, 2'b00, 1'b0);
    send_beat(64'h9999_0000_0000_0002, 2'b00, 1'b1);
    check_done(d0);
    d0 = done_seen;
    start_fill(32'h0000_4004, 1'b0);
    ar_phase(32'h0000_4000, 0);
    four_beats(64'h0C0C_0000_0000_0010);
    check_done(d0);
  endtask

  task automatic test_reset_mid_burst();
    int d0 = done_seen;
    start_fill(32'h0000_5055, 1'b0);
    ar_phase(32'h0000_5040, 0);
    send_beat(64'hDEAD_0000_0000_0001, 2'b00, 1'b0);
    send_beat(64'hDEAD_0000_0000_0002, 2'b00, 1'b0);
    i_rst = 1'b1;
    #2;
    model_blk = '0;
    vectors++;
    if ({o_arvalid, o_rready, o_mem_done, o_bus_err} !== 4'b0 || o_araddr !== '0 || o_block !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: ctl=%b araddr=%h block=%h required 0",
               {o_arvalid, o_rready, o_mem_done, o_bus_err}, o_araddr, o_block);
    end
    tick();
    i_rst = 1'b0;
    tick();
    tick();
    vectors++;
    if (done_seen !== d0 || o_arvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_done: pulses=%0d arvalid=%b required 0 0", done_seen - d0, o_arvalid);
    end
    start_fill(32'h0000_6000, 1'b0);
    ar_phase(32'h0000_6000, 2);
    four_beats(64'h0000_0000_0000_1111);
    check_done(d0);
  endtask

  task automatic test_back_to_back();
    int d0 = done_seen;
    start_fill(32'h0000_7000, 1'b1);
    ar_phase(32'h0000_7000, 0);
    four_beats(64'h0000_0007_0000_0000);
    i_addr = 32'h0000_8039;
    check_done(d0);
    tick();
    i_mem_req = 1'b0;
    model_slot = 0;
    model_err  = 1'b0;
    d0 = done_seen;
    ar_phase(32'h0000_8020, 0);
    four_beats(64'h0000_0008_0000_0000);
    check_done(d0);
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_ar_backpressure();
    test_r_gaps();
    test_slverr();
    test_early_rlast();
    test_reset_mid_burst();
    test_back_to_back();
    tick();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: %0d pending fills required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
